mem_io_responder: RTL and testbench

Memory-side responder for the RISC machine's CPU memory interface. It accepts CPU read/write requests (`mem_cmd`, `mem_addr`, `write_data`), serves them from an internal 16-bit RAM or from memory-mapped switch/LED registers, and signals completion with a one-cycle `mem_ready` pulse after a configurable latency. It sits between the CPU and the board I/O in the lab-8 top level, replacing the combinational RAM/tri-state I/O decode.

---
 rtl/mem_io_responder.sv | 128 ++++++++++++
 tb/tb_mem_io_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - CPU memory responder: RAM plus switch/LED registers with a fixed-latency ready pulse
module mem_io_responder #(
  parameter int         READ_LAT  = 1,
  parameter int         RAM_WORDS = 256,
  parameter logic [8:0] LED_ADDR  = 9'h100,
  parameter logic [8:0] SW_ADDR   = 9'h140
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        mem_ready,
  input  logic [7:0]  SW,
  output logic [7:0]  LEDR,
  output logic        err
);

  localparam int         AW      = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [9:0] RAM_LIM = 10'(RAM_WORDS);
  localparam logic [2:0] LAT_M1  = 3'(READ_LAT - 1);
  localparam logic [1:0] MNONE   = 2'b00;
  localparam logic [1:0] MREAD   = 2'b01;
  localparam logic [1:0] MWRITE  = 2'b10;
  localparam logic [1:0] MILL    = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, next_state;
  logic [2:0]  cnt;
  logic [1:0]  lat_cmd;
  logic [8:0]  lat_addr;
  logic [7:0]  sw_meta, sw_sync;
  logic [15:0] ram [RAM_WORDS];

  logic        accept, enter_done;
  logic [1:0]  src_cmd;
  logic [8:0]  src_addr;
  logic [AW-1:0] src_idx;
  logic        s_ram, s_led, s_sw, s_bad;
  logic [15:0] ram_rd, rd_next;

  // In IDLE the live request is decoded; afterwards the latched one is, so READ_LAT=1 works too.
  always_comb begin
    src_cmd  = (state == IDLE) ? mem_cmd  : lat_cmd;
    src_addr = (state == IDLE) ? mem_addr : lat_addr;
    src_idx  = src_addr[AW-1:0];
    s_ram    = ({1'b0, src_addr} < RAM_LIM);
    s_led    = !s_ram && (src_addr == LED_ADDR);
    s_sw     = !s_ram && (src_addr == SW_ADDR);
    s_bad    = (src_cmd == MILL) || !(s_ram || s_led || s_sw) ||
               ((src_cmd == MWRITE) && s_sw);
    ram_rd   = ram[src_idx];
    if (s_bad)      rd_next = 16'h0000;
    else if (s_ram) rd_next = ram_rd;
    else if (s_led) rd_next = {8'h00, LEDR};
    else            rd_next = {8'h00, sw_sync};
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    enter_done = 1'b0;
    case (state)
      IDLE: begin
        if (mem_cmd != MNONE) begin
          accept = 1'b1;
          if (READ_LAT == 1) begin
            next_state = DONE;
            enter_done = 1'b1;
          end else begin
            next_state = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt <= 3'd1) begin
          next_state = DONE;
          enter_done = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= 3'd0;
      lat_cmd   <= MNONE;
      lat_addr  <= 9'd0;
      read_data <= 16'h0000;
      mem_ready <= 1'b0;
      LEDR      <= 8'h00;
      err       <= 1'b0;
      sw_meta   <= 8'h00;
      sw_sync   <= 8'h00;
    end else begin
      sw_meta   <= SW;
      sw_sync   <= sw_meta;
      mem_ready <= enter_done;
      if (accept) begin
        lat_cmd  <= mem_cmd;
        lat_addr <= mem_addr;
        cnt      <= LAT_M1;
        if (s_bad) err <= 1'b1;
        if ((mem_cmd == MWRITE) && s_led && !s_bad) LEDR <= write_data[7:0];
      end else if (state == BUSY) begin
        cnt <= cnt - 3'd1;
      end
      // Legal writes leave read_data alone; illegal accesses of any kind return zero.
      if (enter_done && (s_bad || (src_cmd == MREAD))) read_data <= rd_next;
    end
  end

  // RAM has no reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (reset_n && accept && (mem_cmd == MWRITE) && s_ram && !s_bad)
      ram[src_idx] <= write_data;
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - scoreboard bench for mem_io_responder at READ_LAT 1, 3 and 4
module tb_mem_io_responder;

  typedef struct {
    int          dut;
    logic        chk;
    logic [15:0] rd;
    logic        er;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [7:0]  sw;
  logic [1:0]  cmd_v   [3];
  logic [8:0]  addr_v  [3];
  logic [15:0] wdata_v [3];
  logic [15:0] rd_v    [3];
  logic        rdy_v   [3];
  logic [7:0]  led_v   [3];
  logic        err_v   [3];

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_io_responder #(.READ_LAT(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .mem_cmd(cmd_v[0]), .mem_addr(addr_v[0]),
    .write_data(wdata_v[0]), .read_data(rd_v[0]), .mem_ready(rdy_v[0]),
    .SW(sw), .LEDR(led_v[0]), .err(err_v[0]));

  mem_io_responder #(.READ_LAT(3)) u_lat3 (
    .clk(clk), .reset_n(reset_n), .mem_cmd(cmd_v[1]), .mem_addr(addr_v[1]),
    .write_data(wdata_v[1]), .read_data(rd_v[1]), .mem_ready(rdy_v[1]),
    .SW(sw), .LEDR(led_v[1]), .err(err_v[1]));

  mem_io_responder #(.READ_LAT(4)) u_lat4 (
    .clk(clk), .reset_n(reset_n), .mem_cmd(cmd_v[2]), .mem_addr(addr_v[2]),
    .write_data(wdata_v[2]), .read_data(rd_v[2]), .mem_ready(rdy_v[2]),
    .SW(sw), .LEDR(led_v[2]), .err(err_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 4;
  endfunction

  // Completion monitor: every ready pulse pops one expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rdy_v[d] === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("spurious_ready", 32'(d), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("ready_dut", 32'(d), 32'(e.dut));
          if (e.chk) check("read_data", 32'(rd_v[d]), 32'(e.rd));
          check("err", 32'(err_v[d]), 32'(e.er));
        end
      end
    end
  end

  // One transaction: drive, measure latency, drop the command, confirm a one-cycle pulse.
  task automatic txn(input int d, input logic [1:0] c, input logic [8:0] a,
                     input logic [15:0] wd, input logic chk, input logic [15:0] erd,
                     input logic er, input logic glitch);
    exp_t e;
    int n;
    e.dut = d; e.chk = chk; e.rd = erd; e.er = er;
    sb_q.push_back(e);
    @(negedge clk);
    cmd_v[d] = c; addr_v[d] = a; wdata_v[d] = wd;
    @(posedge clk); #1;
    n = 1;
    while (rdy_v[d] !== 1'b1 && n < 20) begin
      if (glitch && n == 1) begin
        cmd_v[d] = 2'b10; addr_v[d] = 9'd0; wdata_v[d] = 16'hDEAD;
      end
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(lat_of(d)));
    cmd_v[d] = 2'b00;
    @(posedge clk); #1;
    check("ready_width", 32'(rdy_v[d]), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    sw = 8'h00;
    for (int d = 0; d < 3; d++) begin
      cmd_v[d] = 2'b10; addr_v[d] = 9'd25; wdata_v[d] = 16'h5555;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(rdy_v[0]), 32'd0);
    check("rst_led", 32'(led_v[0]), 32'd0);
    check("rst_err", 32'(err_v[0]), 32'd0);
    check("rst_rdata", 32'(rd_v[0]), 32'd0);
    for (int d = 0; d < 3; d++) cmd_v[d] = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;

    // READ_LAT=1 write/read round trip, plus the last RAM word
    txn(0, 2'b10, 9'd25,  16'hFFE9, 1'b0, 16'h0000, 1'b0, 1'b0);
    txn(0, 2'b01, 9'd25,  16'h0000, 1'b1, 16'hFFE9, 1'b0, 1'b0);
    txn(0, 2'b10, 9'd255, 16'h7E57, 1'b0, 16'h0000, 1'b0, 1'b0);
    txn(0, 2'b01, 9'd255, 16'h0000, 1'b1, 16'h7E57, 1'b0, 1'b0);

    // A write request held through reset must not reach RAM
    @(negedge clk);
    reset_n = 1'b0;
    cmd_v[0] = 2'b10; addr_v[0] = 9'd25; wdata_v[0] = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmd_v[0] = 2'b00;
    reset_n = 1'b1;
    txn(0, 2'b01, 9'd25, 16'h0000, 1'b1, 16'hFFE9, 1'b0, 1'b0);

    // READ_LAT=3, command changes during BUSY are ignored
    txn(1, 2'b10, 9'd0, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0);
    txn(1, 2'b01, 9'd0, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b1);
    txn(1, 2'b01, 9'd0, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0);

    // Memory-mapped I/O
    txn(0, 2'b10, 9'h100, 16'h12A5, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("ledr", 32'(led_v[0]), 32'h0000_00A5);
    @(negedge clk);
    sw = 8'h3C;
    repeat (2) @(posedge clk);
    txn(0, 2'b01, 9'h140, 16'h0000, 1'b1, 16'h003C, 1'b0, 1'b0);
    txn(0, 2'b01, 9'h100, 16'h0000, 1'b1, 16'h00A5, 1'b0, 1'b0);

    // Illegal accesses: sticky err, zero read data, no side effects
    txn(0, 2'b01, 9'h1F0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    txn(0, 2'b10, 9'h140, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("ledr_after_bad_wr", 32'(led_v[0]), 32'h0000_00A5);
    txn(0, 2'b01, 9'h100, 16'h0000, 1'b1, 16'h00A5, 1'b1, 1'b0);
    txn(0, 2'b11, 9'd25,  16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    txn(0, 2'b01, 9'd25,  16'h0000, 1'b1, 16'hFFE9, 1'b1, 1'b0);

    // READ_LAT=4 aborted by reset two cycles after acceptance
    txn(2, 2'b10, 9'd0, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    cmd_v[2] = 2'b01; addr_v[2] = 9'd0;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    cmd_v[2] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_ready", 32'(rdy_v[2]), 32'd0);
    end
    check("abort_rdata", 32'(rd_v[2]), 32'd0);
    check("abort_err0", 32'(err_v[0]), 32'd0);
    check("abort_led0", 32'(led_v[0]), 32'd0);
    reset_n = 1'b1;
    txn(2, 2'b01, 9'd0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
